// File: rtl/alu_nbit_seq.sv
// alu_nbit_seq: registered WIDTH-bit ALU with status flags, set-less-than and
// an optional shift-add unsigned multiply behind a start/busy/done handshake.
// Optional feature macro: ALU_MUL_EN (compiles in MUL op, MUL/FIN states,
// iteration counter and product registers).
module alu_nbit_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluControl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] resultHi,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       ctl_q, ctl_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             accept;

  // single-cycle datapath signals
  logic [WIDTH-1:0] a_x, b_x;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;
  logic [WIDTH-1:0] ex_res;
  logic             ex_carry, ex_ovf;

`ifdef ALU_MUL_EN
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   mul_add;
  logic             is_mul;

  assign busy     = busy_q;
  assign resultHi = hi_q;
`else
  assign busy     = 1'b0;
  assign resultHi = '0;
`endif

  assign done     = done_q;
  assign result   = result_q;
  assign carryOut = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

  // Single-cycle ALU on the captured operands: invert, add with internal carry-in, select
  always_comb begin
    a_x      = ctl_q[3] ? ~a_q : a_q;
    b_x      = ctl_q[2] ? ~b_q : b_q;
    sum      = {1'b0, a_x} + {1'b0, b_x} + {{WIDTH{1'b0}}, ctl_q[2]};
    sum_ovf  = (a_x[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != a_x[WIDTH-1]);
    ex_res   = '0;
    ex_carry = 1'b0;
    ex_ovf   = 1'b0;
    case (ctl_q)
      4'b0000, 4'b1100: ex_res = a_x & b_x;
      4'b0001:          ex_res = a_x | b_x;
      4'b0010, 4'b0110: begin
        ex_res   = sum[WIDTH-1:0];
        ex_carry = sum[WIDTH];
        ex_ovf   = sum_ovf;
      end
      4'b0111:          ex_res[0] = sum[WIDTH-1] ^ sum_ovf;
      default:          ex_res = '0;
    endcase
  end

  // Next-state logic: FSM sequencing, output capture, multiply iteration
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ctl_d    = ctl_q;
    done_d   = 1'b0;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
`ifdef ALU_MUL_EN
    hi_d      = hi_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    cnt_d     = cnt_q;
    busy_d    = (state_q == S_MUL);
    is_mul    = (aluControl == 4'b0011);
    mul_add   = {1'b0, prod_hi_q} + (prod_lo_q[0] ? {1'b0, a_q} : '0);
    // MUL state is excluded explicitly: busy lags the state by one cycle
    accept    = start && !busy_q && (state_q != S_MUL);
`else
    accept    = start;
`endif

    case (state_q)
      S_EXEC: begin
        result_d = ex_res;
        carry_d  = ex_carry;
        ovf_d    = ex_ovf;
        zero_d   = (ex_res == '0);
        done_d   = 1'b1;
        state_d  = S_IDLE;
`ifdef ALU_MUL_EN
        hi_d     = '0;
`endif
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        // shift-add step: add multiplicand into high word, shift product right
        {prod_hi_d, prod_lo_d} = {mul_add, prod_lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        result_d = prod_lo_q;
        hi_d     = prod_hi_q;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        zero_d   = (prod_lo_q == '0) && (prod_hi_q == '0);
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      a_d     = a;
      b_d     = b;
      ctl_d   = aluControl;
      state_d = S_EXEC;
`ifdef ALU_MUL_EN
      if (is_mul) begin
        state_d   = S_MUL;
        prod_hi_d = '0;
        prod_lo_d = b;
        cnt_d     = '0;
      end
`endif
    end
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ctl_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
`ifdef ALU_MUL_EN
      busy_q    <= 1'b0;
      hi_q      <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctl_q    <= ctl_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
`ifdef ALU_MUL_EN
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Directed bench for alu_nbit_seq (WIDTH=8); MUL checks follow ALU_MUL_EN.
module tb_alu_nbit_seq;

  logic       clk = 1'b0;
  logic       resetN;
  logic       start;
  logic [7:0] a, b;
  logic [3:0] aluControl;
  logic       busy, done, carryOut, overflow, zero;
  logic [7:0] result, resultHi;

  int errors = 0;
  int checks = 0;
  int done_cnt;

  alu_nbit_seq #(.WIDTH(8)) dut (
    .clk(clk), .resetN(resetN), .start(start), .a(a), .b(b),
    .aluControl(aluControl), .busy(busy), .done(done), .result(result),
    .resultHi(resultHi), .carryOut(carryOut), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue one op for a single edge, then wait one more edge
  task automatic op(input logic [7:0] va, input logic [7:0] vb, input logic [3:0] c);
    a = va; b = vb; aluControl = c; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic chk_out(input string tag, input logic [7:0] r, input logic [7:0] rh,
                         input logic c, input logic v, input logic z);
    chk({tag, ".done"}, {15'd0, done}, 16'd1);
    chk({tag, ".result"}, {8'd0, result}, {8'd0, r});
    chk({tag, ".resultHi"}, {8'd0, resultHi}, {8'd0, rh});
    chk({tag, ".carry"}, {15'd0, carryOut}, {15'd0, c});
    chk({tag, ".ovf"}, {15'd0, overflow}, {15'd0, v});
    chk({tag, ".zero"}, {15'd0, zero}, {15'd0, z});
  endtask

  initial begin
    resetN = 1'b1; start = 1'b0; a = '0; b = '0; aluControl = '0;
    #2 resetN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.done", {15'd0, done}, 16'd0);
    chk("rst.busy", {15'd0, busy}, 16'd0);
    chk("rst.result", {resultHi, result}, 16'h0000);
    chk("rst.flags", {13'd0, carryOut, overflow, zero}, 16'd0);
    @(negedge clk) resetN = 1'b1;
    tick();

    // ADD 7F+01: signed overflow, latency one edge
    a = 8'h7F; b = 8'h01; aluControl = 4'b0010; start = 1'b1;
    tick();
    start = 1'b0;
    chk("add.latency", {15'd0, done}, 16'd0);
    tick();
    chk_out("add", 8'h80, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    chk("add.done_pulse", {15'd0, done}, 16'd0);

    // back-to-back SUB
    a = 8'h05; b = 8'h05; aluControl = 4'b0110; start = 1'b1;
    tick();
    a = 8'h03; b = 8'h05;
    tick();
    start = 1'b0;
    chk_out("sub1", 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    a = 8'hAA; b = 8'h11;   // changes after accept must not matter
    tick();
    chk_out("sub2", 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sub.done_low", {15'd0, done}, 16'd0);
    chk("sub.hold", {8'd0, result}, 16'h00FE);

    op(8'hFE, 8'h01, 4'b0111); chk_out("slt1", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    op(8'h01, 8'hFE, 4'b0111); chk_out("slt2", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    op(8'h80, 8'h01, 4'b0111); chk_out("slt3", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    op(8'hF0, 8'h0F, 4'b1100); chk_out("nor", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    op(8'hCC, 8'hAA, 4'b0000); chk_out("and", 8'h88, 8'h00, 1'b0, 1'b0, 1'b0);
    op(8'hCC, 8'hAA, 4'b0001); chk_out("or", 8'hEE, 8'h00, 1'b0, 1'b0, 1'b0);
    op(8'hFF, 8'h01, 4'b0010); chk_out("add_carry", 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    op(8'h12, 8'h34, 4'b1111); chk_out("unsup", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

`ifdef ALU_MUL_EN
    // MUL FF*FF: busy 8 cycles, done at 9, mid-multiply start ignored
    a = 8'hFF; b = 8'hFF; aluControl = 4'b0011; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'h00; b = 8'h00;
    done_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        a = 8'h01; b = 8'h01; aluControl = 4'b0010; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) done_cnt++;
      chk($sformatf("mul.busy%0d", i), {15'd0, busy}, 16'd1);
    end
    start = 1'b0;
    tick();
    if (done) done_cnt++;
    chk("mul.busy_end", {15'd0, busy}, 16'd0);
    chk_out("mul", 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("mul.done_count", done_cnt[15:0], 16'd1);
    chk("mul.hold", {resultHi, result}, 16'hFE01);

    // reset during MUL iteration 4
    a = 8'h0D; b = 8'h0B; aluControl = 4'b0011; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("mulrst.busy_before", {15'd0, busy}, 16'd1);
    resetN = 1'b0;
    #1;
    chk("mulrst.result", {resultHi, result}, 16'h0000);
    chk("mulrst.ctl", {12'd0, busy, done, carryOut | overflow, zero}, 16'd0);
    @(negedge clk) resetN = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("mulrst.no_done", done_cnt[15:0], 16'd0);
`else
    // MUL code is unsupported: single-cycle, zero result, never busy
    a = 8'h03; b = 8'h04; aluControl = 4'b0011; start = 1'b1;
    tick();
    start = 1'b0;
    chk("nomul.busy", {15'd0, busy}, 16'd0);
    tick();
    chk_out("nomul", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("nomul.busy2", {15'd0, busy}, 16'd0);

    // asynchronous reset clears a non-zero result immediately
    op(8'h20, 8'h22, 4'b0010);
    chk("prerst.result", {8'd0, result}, 16'h0042);
    a = 8'h01; b = 8'h02; aluControl = 4'b0010; start = 1'b1;
    tick();
    start = 1'b0;
    resetN = 1'b0;
    #1;
    chk("rst2.result", {resultHi, result}, 16'h0000);
    chk("rst2.ctl", {12'd0, busy, done, carryOut | overflow, zero}, 16'd0);
    @(negedge clk) resetN = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("rst2.no_done", done_cnt[15:0], 16'd0);
`endif

    op(8'h01, 8'h01, 4'b0010); chk_out("post_rst_add", 8'h02, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
